// File: rtl/elevator_ctrl_n.sv
// Single-car elevator controller: latches call buttons, travels floor by floor,
// holds the door open for a fixed time and latches into an emergency stop.
module elevator_ctrl_n #(
    parameter int NUM_FLOORS  = 4,
    parameter int MOVE_CYCLES = 2,
    parameter int DOOR_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] floor_req,
    input  logic                  emerg_in,
    output logic                  emerg_out,
    output logic [3:0]            Disp_1,
    output logic [3:0]            Disp_2,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] req_pending
);
    localparam int MW = $clog2(MOVE_CYCLES + 1);
    localparam int DW = $clog2(DOOR_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_MOVE_UP, S_MOVE_DOWN, S_DOOR_OPEN, S_EMERG
    } state_t;

    state_t                  state_reg, state_next;
    logic [3:0]              floor_reg, floor_next;
    logic                    dir_up_reg, dir_up_next;
    logic [MW-1:0]           move_cnt_reg, move_cnt_next;
    logic [DW-1:0]           door_cnt_reg, door_cnt_next;
    logic [NUM_FLOORS-1:0]   pend_reg, pend_next;

    logic [31:0]             floor_w;
    logic [NUM_FLOORS-1:0]   here_vec, above_vec, below_vec, cur_vec, req_here_vec;
    logic [NUM_FLOORS-1:0]   up_next_vec, dn_next_vec, beyond_up_vec, beyond_dn_vec;
    logic [NUM_FLOORS-1:0]   latch_vec, clear_vec;

    assign floor_w = {28'd0, floor_reg};

    // Per-floor position masks relative to the current floor and its neighbours
    generate
        for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
            localparam logic [31:0] IDX = gi;
            assign cur_vec[gi]       = (IDX == floor_w);
            assign here_vec[gi]      = pend_reg[gi] && (IDX == floor_w);
            assign above_vec[gi]     = pend_reg[gi] && (IDX > floor_w);
            assign below_vec[gi]     = pend_reg[gi] && (IDX < floor_w);
            assign up_next_vec[gi]   = pend_reg[gi] && (IDX == floor_w + 32'd1);
            assign beyond_up_vec[gi] = pend_reg[gi] && (IDX > floor_w + 32'd1);
            assign dn_next_vec[gi]   = pend_reg[gi] && (IDX + 32'd1 == floor_w);
            assign beyond_dn_vec[gi] = pend_reg[gi] && (IDX + 32'd1 < floor_w);
            assign req_here_vec[gi]  = floor_req[gi] && (IDX == floor_w);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            floor_reg    <= '0;
            dir_up_reg   <= 1'b1;
            move_cnt_reg <= '0;
            door_cnt_reg <= '0;
            pend_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            floor_reg    <= floor_next;
            dir_up_reg   <= dir_up_next;
            move_cnt_reg <= move_cnt_next;
            door_cnt_reg <= door_cnt_next;
            pend_reg     <= pend_next;
        end
    end

    // Decisions use the already-latched requests; new presses land in pend_next
    always_comb begin
        state_next    = state_reg;
        floor_next    = floor_reg;
        dir_up_next   = dir_up_reg;
        move_cnt_next = move_cnt_reg;
        door_cnt_next = door_cnt_reg;
        latch_vec     = floor_req;
        clear_vec     = '0;
        case (state_reg)
            S_IDLE: begin
                if (|here_vec) begin
                    state_next    = S_DOOR_OPEN;
                    door_cnt_next = '0;
                    clear_vec     = here_vec;
                end else if ((|above_vec) && ((|below_vec) ? dir_up_reg : 1'b1)) begin
                    state_next    = S_MOVE_UP;
                    dir_up_next   = 1'b1;
                    move_cnt_next = '0;
                end else if (|below_vec) begin
                    state_next    = S_MOVE_DOWN;
                    dir_up_next   = 1'b0;
                    move_cnt_next = '0;
                end
            end
            S_MOVE_UP, S_MOVE_DOWN: begin
                if (move_cnt_reg == MW'(MOVE_CYCLES - 1)) begin
                    move_cnt_next = '0;
                    if (state_reg == S_MOVE_UP) begin
                        floor_next = floor_reg + 4'd1;
                        if (|up_next_vec) begin
                            state_next    = S_DOOR_OPEN;
                            door_cnt_next = '0;
                            clear_vec     = up_next_vec;
                        end else if (!(|beyond_up_vec)) begin
                            state_next = S_IDLE;
                        end
                    end else begin
                        floor_next = floor_reg - 4'd1;
                        if (|dn_next_vec) begin
                            state_next    = S_DOOR_OPEN;
                            door_cnt_next = '0;
                            clear_vec     = dn_next_vec;
                        end else if (!(|beyond_dn_vec)) begin
                            state_next = S_IDLE;
                        end
                    end
                end else begin
                    move_cnt_next = move_cnt_reg + MW'(1);
                end
            end
            S_DOOR_OPEN: begin
                latch_vec = floor_req & ~cur_vec;
                if (|req_here_vec) begin
                    door_cnt_next = '0;
                end else if (door_cnt_reg == DW'(DOOR_CYCLES - 1)) begin
                    state_next    = S_IDLE;
                    door_cnt_next = '0;
                end else begin
                    door_cnt_next = door_cnt_reg + DW'(1);
                end
            end
            default: begin
                latch_vec = '0;
            end
        endcase
        pend_next = (pend_reg | latch_vec) & ~clear_vec;
        // Emergency wins over every other transition but keeps the car where it is
        if (state_reg != S_EMERG && emerg_in) begin
            state_next    = S_EMERG;
            floor_next    = floor_reg;
            move_cnt_next = '0;
            door_cnt_next = '0;
            pend_next     = '0;
        end
    end

    always_comb begin
        emerg_out = 1'b0;
        door_open = 1'b0;
        Disp_2    = 4'd0;
        case (state_reg)
            S_MOVE_UP:   Disp_2 = 4'd1;
            S_MOVE_DOWN: Disp_2 = 4'd2;
            S_DOOR_OPEN: begin
                Disp_2    = 4'd3;
                door_open = 1'b1;
            end
            S_EMERG: begin
                Disp_2    = 4'd14;
                emerg_out = 1'b1;
            end
            default: ;
        endcase
    end

    assign Disp_1      = floor_reg;
    assign req_pending = pend_reg;
endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Randomized bench: three controller sizes run side by side against a countdown-style
// behavioural model, plus directed call scenarios and asynchronous reset checks.
module tb_elevator_ctrl_n;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] req4;
    logic [1:0] req2;
    logic [9:0] req10;
    logic       em4, em2, em10;
    logic       eo4, eo2, eo10, dr4, dr2, dr10;
    logic [3:0] d1_4, d2_4, d1_2, d2_2, d1_10, d2_10;
    logic [3:0] pend4;
    logic [1:0] pend2;
    logic [9:0] pend10;

    int checks = 0;
    int failures = 0;

    elevator_ctrl_n #(.NUM_FLOORS(4), .MOVE_CYCLES(2), .DOOR_CYCLES(3)) dut4 (
        .clk(clk), .reset(rst_n), .floor_req(req4), .emerg_in(em4), .emerg_out(eo4),
        .Disp_1(d1_4), .Disp_2(d2_4), .door_open(dr4), .req_pending(pend4));
    elevator_ctrl_n #(.NUM_FLOORS(2), .MOVE_CYCLES(1), .DOOR_CYCLES(1)) dut2 (
        .clk(clk), .reset(rst_n), .floor_req(req2), .emerg_in(em2), .emerg_out(eo2),
        .Disp_1(d1_2), .Disp_2(d2_2), .door_open(dr2), .req_pending(pend2));
    elevator_ctrl_n #(.NUM_FLOORS(10), .MOVE_CYCLES(3), .DOOR_CYCLES(2)) dut10 (
        .clk(clk), .reset(rst_n), .floor_req(req10), .emerg_in(em10), .emerg_out(eo10),
        .Disp_1(d1_10), .Disp_2(d2_10), .door_open(dr10), .req_pending(pend10));

    // mode holds the expected status code; left counts edges until the next event
    typedef struct {
        int        nf, mc, dc;
        int        floor;
        int        mode;
        int        left;
        bit        dir_up;
        bit [15:0] pend;
    } model_t;

    model_t m4, m2, m10;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic model_t model_reset(input model_t m);
        model_t n = m;
        n.floor  = 0;
        n.mode   = 0;
        n.left   = 0;
        n.dir_up = 1'b1;
        n.pend   = '0;
        return n;
    endfunction

    function automatic model_t model_step(input model_t m, input bit [15:0] req, input bit emerg);
        model_t    n = m;
        bit [15:0] old = m.pend;
        bit [15:0] latch = req;
        int        serve = -1;
        bit        up_any = 1'b0, dn_any = 1'b0, further = 1'b0, go_up;
        if (m.mode == 14) return m;
        if (emerg) begin
            n.mode = 14;
            n.pend = '0;
            n.left = 0;
            return n;
        end
        if (m.mode == 3) latch[m.floor] = 1'b0;
        for (int i = 0; i < m.nf; i++) begin
            if (old[i] && i > m.floor) up_any = 1'b1;
            if (old[i] && i < m.floor) dn_any = 1'b1;
        end
        case (m.mode)
            0: begin
                if (old[m.floor]) begin
                    n.mode = 3; n.left = m.dc; serve = m.floor;
                end else if (up_any || dn_any) begin
                    go_up    = (up_any && dn_any) ? m.dir_up : up_any;
                    n.mode   = go_up ? 1 : 2;
                    n.dir_up = go_up;
                    n.left   = m.mc;
                end
            end
            1, 2: begin
                n.left = m.left - 1;
                if (n.left == 0) begin
                    n.floor = m.floor + ((m.mode == 1) ? 1 : -1);
                    for (int i = 0; i < m.nf; i++)
                        if (old[i] && ((m.mode == 1 && i > n.floor) || (m.mode == 2 && i < n.floor)))
                            further = 1'b1;
                    if (old[n.floor]) begin
                        n.mode = 3; n.left = m.dc; serve = n.floor;
                    end else if (further) begin
                        n.left = m.mc;
                    end else begin
                        n.mode = 0;
                    end
                end
            end
            3: begin
                if (req[m.floor]) n.left = m.dc;
                else begin
                    n.left = m.left - 1;
                    if (n.left == 0) n.mode = 0;
                end
            end
            default: ;
        endcase
        n.pend = old | latch;
        if (serve >= 0) n.pend[serve] = 1'b0;
        return n;
    endfunction

    task automatic compare_inst(input string nm, input logic [3:0] d1, input logic [3:0] d2,
                                input logic dr, input logic eo, input logic [15:0] pend, input model_t m);
        check_val({nm, ".Disp_1"}, 32'(d1), m.floor);
        check_val({nm, ".Disp_2"}, 32'(d2), m.mode);
        check_val({nm, ".door_open"}, 32'(dr), (m.mode == 3) ? 32'd1 : 32'd0);
        check_val({nm, ".emerg_out"}, 32'(eo), (m.mode == 14) ? 32'd1 : 32'd0);
        check_val({nm, ".req_pending"}, 32'(pend), 32'(m.pend));
    endtask

    // Called at a falling edge: drives inputs, takes one rising edge, compares at the next fall
    task automatic step(input bit [3:0] r4, input bit [1:0] r2, input bit [9:0] r10,
                        input bit e4, input bit e2, input bit e10);
        req4 = r4; req2 = r2; req10 = r10;
        em4 = e4; em2 = e2; em10 = e10;
        @(posedge clk);
        m4  = model_step(m4,  {12'd0, r4},  e4);
        m2  = model_step(m2,  {14'd0, r2},  e2);
        m10 = model_step(m10, {6'd0, r10}, e10);
        @(negedge clk);
        compare_inst("n4",  d1_4,  d2_4,  dr4,  eo4,  {12'd0, pend4},  m4);
        compare_inst("n2",  d1_2,  d2_2,  dr2,  eo2,  {14'd0, pend2},  m2);
        compare_inst("n10", d1_10, d2_10, dr10, eo10, {6'd0, pend10}, m10);
    endtask

    task automatic do_reset();
        req4 = '0; req2 = '0; req10 = '0;
        em4 = 1'b0; em2 = 1'b0; em10 = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("rst.n4.outs", {19'd0, d1_4, d2_4, dr4, eo4, pend4}, 32'd0);
        check_val("rst.n2.outs", {21'd0, d1_2, d2_2, dr2, eo2, pend2}, 32'd0);
        check_val("rst.n10.outs", {13'd0, d1_10, d2_10, dr10, eo10, pend10}, 32'd0);
        m4 = model_reset(m4); m2 = model_reset(m2); m10 = model_reset(m10);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n_cyc;
        int em_at;
        m4.nf = 4;   m4.mc = 2;  m4.dc = 3;
        m2.nf = 2;   m2.mc = 1;  m2.dc = 1;
        m10.nf = 10; m10.mc = 3; m10.dc = 2;
        rst_n = 1'b1;
        @(negedge clk);
        do_reset();

        // Call to floor 2 from floor 0 with exact arrival timing
        for (int k = 0; k <= 8; k++) begin
            step((k == 0) ? 4'b0100 : 4'b0000, 2'b00, 10'd0, 1'b0, 1'b0, 1'b0);
            if (k == 1) check_val("trip.move_up", 32'(d2_4), 32'd1);
            if (k == 3) check_val("trip.floor1", 32'(d1_4), 32'd1);
            if (k == 5) begin
                check_val("trip.floor2", 32'(d1_4), 32'd2);
                check_val("trip.door", 32'(dr4), 32'd1);
                check_val("trip.status_door", 32'(d2_4), 32'd3);
            end
            if (k == 8) begin
                check_val("trip.idle", 32'(d2_4), 32'd0);
                check_val("trip.pending", 32'(pend4), 32'd0);
            end
        end
        $display("scenario trip_to_floor2 checks=%0d failures=%0d", checks, failures);

        // Calls at the current floor, repeated presses keep the door open
        do_reset();
        for (int k = 0; k < 14; k++)
            step((k == 0 || k == 3 || k == 5) ? 4'b0001 : 4'b0000,
                 (k == 0) ? 2'b10 : 2'b00, (k == 0) ? 10'h200 : 10'd0, 1'b0, 1'b0, 1'b0);
        check_val("door.floor_held", 32'(d1_4), 32'd0);
        $display("scenario door_hold checks=%0d failures=%0d", checks, failures);

        // Go to floor 1, then calls above and below: up wins, floor 0 last
        do_reset();
        step(4'b0010, 2'b00, 10'd0, 1'b0, 1'b0, 1'b0);
        repeat (10) step(4'b0000, 2'b00, 10'd0, 1'b0, 1'b0, 1'b0);
        step(4'b1001, 2'b01, 10'h001, 1'b0, 1'b0, 1'b0);
        repeat (30) step(4'b0000, 2'b00, 10'd0, 1'b0, 1'b0, 1'b0);
        check_val("both_dirs.final_floor", 32'(d1_4), 32'd0);
        check_val("both_dirs.final_pending", 32'(pend4), 32'd0);
        $display("scenario both_directions checks=%0d failures=%0d", checks, failures);

        // Emergency between floors 1 and 2, requests ignored, then reset recovery
        do_reset();
        step(4'b0100, 2'b10, 10'h020, 1'b0, 1'b0, 1'b0);
        repeat (3) step(4'b0000, 2'b00, 10'd0, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 2'b00, 10'd0, 1'b1, 1'b1, 1'b1);
        check_val("emerg.status", 32'(d2_4), 32'd14);
        check_val("emerg.floor_held", 32'(d1_4), 32'd1);
        repeat (6) step(4'($urandom), 2'($urandom), 10'($urandom), 1'($urandom), 1'b0, 1'b1);
        do_reset();
        step(4'b0010, 2'b01, 10'h002, 1'b0, 1'b0, 1'b0);
        repeat (6) step(4'b0000, 2'b00, 10'd0, 1'b0, 1'b0, 1'b0);
        check_val("recover.floor1", 32'(d1_4), 32'd1);
        $display("scenario emergency_reset checks=%0d failures=%0d", checks, failures);

        // Random traffic, occasional emergency, reset between segments
        for (int seg = 0; seg < 10; seg++) begin
            do_reset();
            n_cyc = 250;
            em_at = $urandom_range(60, 500);
            for (int c = 0; c < n_cyc; c++) begin
                step(($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'd0,
                     ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0,
                     ($urandom_range(0, 4) == 0) ? 10'(1 << $urandom_range(0, 9)) : 10'd0,
                     c == em_at, c == em_at + 7, c == em_at + 13);
            end
            $display("random segment %0d emerg_at=%0d checks=%0d failures=%0d", seg, em_at, checks, failures);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/elevator_ctrl_n.md
ELEVATOR_CTRL_N -- requirements
Module: elevator_ctrl_n

Interface
REQ-001 The module SHALL have parameter NUM_FLOORS, default 4, number of served floors (legal 2..10).
REQ-002 The module SHALL have parameter MOVE_CYCLES, default 2, clock cycles of travel per floor (legal >=1).
REQ-003 The module SHALL have parameter DOOR_CYCLES, default 3, clock cycles the door stays open (legal >=1).
REQ-004 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: floor_req  input  NUM_FLOORS  call buttons, bit i = floor i, sampled every rising edge.
REQ-007 Port: emerg_in  input  1  emergency stop request, sampled every rising edge.
REQ-008 Port: emerg_out  output  1  high while in EMERG.
REQ-009 Port: Disp_1  output  4  current floor number, binary 0..NUM_FLOORS-1.
REQ-010 Port: Disp_2  output  4  status code: 0 IDLE, 1 MOVE_UP, 2 MOVE_DOWN, 3 DOOR_OPEN, 14 EMERG.
REQ-011 Port: door_open  output  1  high in DOOR_OPEN.
REQ-012 Port: req_pending  output  NUM_FLOORS  latched, unserved requests.

Function
REQ-013 States SHALL be IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, EMERG; all outputs registered or decoded from registers only.
REQ-014 Each edge, req_pending SHALL OR in floor_req, except: bit of current floor not set while in DOOR_OPEN (reloads door timer instead); no bits set in EMERG.
REQ-015 IDLE: pending at current floor -> DOOR_OPEN, clear that bit; else pending above and below -> continue last direction (dir register, reset = up); else pending above -> MOVE_UP; else pending below -> MOVE_DOWN; else stay.
REQ-016 MOVE_x: move counter counts 0..MOVE_CYCLES-1; on edge where counter = MOVE_CYCLES-1, floor increments (up) or decrements (down) and counter returns to 0.
REQ-017 On that arrival edge: pending at new floor -> DOOR_OPEN, clear bit; else pending further in same direction -> stay in MOVE_x; else -> IDLE.
REQ-018 Floor SHALL never leave 0..NUM_FLOORS-1; requests for floors outside range do not exist (width-bounded).
REQ-019 DOOR_OPEN: door counter counts 0..DOOR_CYCLES-1, then -> IDLE; a floor_req for the current floor during DOOR_OPEN resets the counter to 0.
REQ-020 emerg_in=1 at any edge in any non-EMERG state -> EMERG on that edge, overriding all other transitions; req_pending cleared; floor held; counters cleared.
REQ-021 EMERG SHALL be left only by reset; floor_req and emerg_in ignored.
REQ-022 dir register SHALL update to up on entry to MOVE_UP, down on entry to MOVE_DOWN.
REQ-023 Disp_2 SHALL reflect current state with zero cycles of latency relative to state register.

Reset
REQ-024 reset=0 SHALL immediately (no clock) force IDLE, floor 0, dir up, counters 0, req_pending 0, emerg_out 0, door_open 0, Disp_1 0, Disp_2 0.
REQ-025 Reset asserted mid-move or in EMERG SHALL abandon the operation; first evaluation occurs on the first rising edge with reset=1.
REQ-026 Requests present on the release edge SHALL be latched normally.

Verification (defaults NUM_FLOORS=4, MOVE_CYCLES=2, DOOR_CYCLES=3)
REQ-027 floor_req=0100 one cycle at edge 0 from floor 0 -> edge1 Disp_2=1; Disp_1=1 after edge 3; Disp_1=2, door_open=1, Disp_2=3 after edge 5; Disp_2=0, req_pending=0 after edge 8.
REQ-028 At floor 0 IDLE, floor_req=0001 -> DOOR_OPEN next edge, no movement; repeated 0001 during door -> door stays open 3 cycles after last press.
REQ-029 At floor 1 after moving up, pending 1001 -> serves floor 3 first (Disp_1 3, door), then floor 0; req_pending 0000 at end.
REQ-030 emerg_in=1 while moving between floor 1 and 2 -> next edge emerg_out=1, Disp_2=14, req_pending=0, Disp_1 held; later floor_req ignored.
REQ-031 Reset low asynchronously in EMERG -> outputs all 0 without clock edge; after release, floor_req=0010 -> normal service to floor 1.
REQ-032 Parameter sweep NUM_FLOORS=2 and 10: top/bottom requests reached, Disp_1 never exceeds NUM_FLOORS-1 or underflows.
